addpoly_engine: RTL and testbench

Self-contained polynomial addition engine for the SNTRUP757 arithmetic core: S = A + B coefficient-wise. It reads operands A and B from two synchronous-read coefficient memories, writes the sum into memory S, and reports the true degree of the result after leading-zero cancellation. It is the additive counterpart of the subtraction datapath and shares its memory-port conventions (26-bit coefficients, 11-bit addresses), but carries its own control FSM.

---
 rtl/addpoly_engine.sv | 161 ++++++++++++++++
 tb/tb_addpoly_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/addpoly_engine.sv
// Coefficient-wise polynomial adder S = A + B over synchronous-read memories, with result-degree tracking.
// Optional ADDPOLY_MODQ_EN compiles in reduction of each sum into [0, Q-1].

module addpoly_sum #(
  parameter int Q = 4591
) (
  input  logic [25:0] a_i,
  input  logic [25:0] b_i,
  input  logic        mask_a_i,
  input  logic        mask_b_i,
  output logic [25:0] s_o,
  output logic        nz_o
);
  logic [25:0] a, b;

  assign a = mask_a_i ? 26'd0 : a_i;
  assign b = mask_b_i ? 26'd0 : b_i;

`ifdef ADDPOLY_MODQ_EN
  logic [26:0] raw, red;
  assign raw = {1'b0, a} + {1'b0, b};
  assign red = raw - 27'(Q);
  assign s_o = (raw >= 27'(Q)) ? red[25:0] : raw[25:0];
`else
  localparam int unused_q = Q;
  assign s_o = a + b;
`endif

  assign nz_o = |s_o;
endmodule

module addpoly_engine #(
  parameter int Q = 4591
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] degA,
  input  logic [10:0] degB,
  input  logic [25:0] mem_outputA,
  input  logic [25:0] mem_outputB,
  output logic [10:0] mem_address_oA,
  output logic [10:0] mem_address_oB,
  output logic [10:0] mem_address_iS,
  output logic [25:0] mem_inputS,
  output logic        write_enableS,
  output logic [10:0] deg,
  output logic        busy,
  output logic        done
);
  localparam int STAGES = 2;

  typedef enum logic [2:0] {IDLE, RUN, FLUSH1, FLUSH2, DONE} state_t;

  // Index and operand masks travel together so they line up with the read data.
  typedef struct packed {
    logic [10:0] idx;
    logic        mask_a;
    logic        mask_b;
  } rd_req_t;

  state_t      state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic [10:0] degA_q, degB_q, dmax;
  logic [10:0] addrS_q;
  logic [25:0] dataS_q;
  logic [10:0] deg_q;
  logic [STAGES:1] vld_pipe_q;
  rd_req_t     s1_q, s1_d;
  logic        accept, issue;
  logic [25:0] sum;
  logic        sum_nz;

  assign dmax   = (degA_q > degB_q) ? degA_q : degB_q;
  assign accept = (state_q == IDLE) && start;
  assign issue  = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          addr_d  = 11'd0;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (addr_q == dmax) state_d = FLUSH1;
        else                addr_d  = addr_q + 11'd1;
      end
      FLUSH1: begin
        busy    = 1'b1;
        state_d = FLUSH2;
      end
      FLUSH2: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_d.idx    = addr_q;
    s1_d.mask_a = addr_q > degA_q;
    s1_d.mask_b = addr_q > degB_q;
  end

  addpoly_sum #(.Q(Q)) u_sum (
    .a_i      (mem_outputA),
    .b_i      (mem_outputB),
    .mask_a_i (s1_q.mask_a),
    .mask_b_i (s1_q.mask_b),
    .s_o      (sum),
    .nz_o     (sum_nz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 11'd0;
      degA_q     <= 11'd0;
      degB_q     <= 11'd0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      addrS_q    <= 11'd0;
      dataS_q    <= 26'd0;
      deg_q      <= 11'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], issue};
      s1_q       <= s1_d;
      if (accept) begin
        degA_q <= degA;
        degB_q <= degB;
      end
      if (vld_pipe_q[1]) begin
        addrS_q <= s1_q.idx;
        dataS_q <= sum;
      end
      if (accept)                       deg_q <= 11'd0;
      else if (vld_pipe_q[1] && sum_nz) deg_q <= s1_q.idx;
    end
  end

  assign mem_address_oA = addr_q;
  assign mem_address_oB = addr_q;
  assign mem_address_iS = addrS_q;
  assign mem_inputS     = dataS_q;
  assign write_enableS  = vld_pipe_q[STAGES];
  assign deg            = deg_q;
endmodule

// File: tb/tb_addpoly_engine.sv
// Directed bench for addpoly_engine: memory models, write scoreboard, done/deg timing and reset/start-ignore cases.
module tb_addpoly_engine;
  localparam int Q = 4591;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [10:0] degA = 11'd0, degB = 11'd0;
  logic [25:0] mem_outputA, mem_outputB;
  logic [10:0] mem_address_oA, mem_address_oB, mem_address_iS, deg;
  logic [25:0] mem_inputS;
  logic        write_enableS, busy, done;

  addpoly_engine #(.Q(Q)) dut (
    .clk(clk), .rst(rst), .start(start), .degA(degA), .degB(degB),
    .mem_outputA(mem_outputA), .mem_outputB(mem_outputB),
    .mem_address_oA(mem_address_oA), .mem_address_oB(mem_address_oB),
    .mem_address_iS(mem_address_iS), .mem_inputS(mem_inputS),
    .write_enableS(write_enableS), .deg(deg), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [25:0] memA [2048];
  logic [25:0] memB [2048];
  logic [25:0] memS [2048];
  logic [25:0] expS [2048];

  always @(posedge clk) begin
    mem_outputA <= memA[mem_address_oA];
    mem_outputB <= memB[mem_address_oB];
    if (write_enableS) memS[mem_address_iS] <= mem_inputS;
  end

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;
  wr_t q[$];

  int total = 0, bad = 0;
  int cur_dm, cur_deg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] model_sum(input logic [25:0] a, input logic [25:0] b);
    logic [26:0] r;
    r = {1'b0, a} + {1'b0, b};
`ifdef ADDPOLY_MODQ_EN
    if (r >= 27'(Q)) r = r - 27'(Q);
`endif
    return r[25:0];
  endfunction

  // Caller must be away from a posedge (normally at a negedge) in an IDLE cycle.
  task automatic issue(input int dA, input int dB, output int e0);
    logic [25:0] a, b, s;
    degA  = 11'(dA);
    degB  = 11'(dB);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e0    = cyc;
    chk("busy_on", busy, 1);
    chk("deg_clr", deg, 0);
    cur_dm  = (dA > dB) ? dA : dB;
    cur_deg = 0;
    for (int k = 0; k <= cur_dm; k++) begin
      a = (k > dA) ? 26'd0 : memA[k];
      b = (k > dB) ? 26'd0 : memB[k];
      s = model_sum(a, b);
      expS[k] = s;
      if (s != 26'd0) cur_deg = k;
      q.push_back('{k, int'(s), e0 + k + 2});
    end
  endtask

  task automatic wait_done(input int e0, input bit start_in_done);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 200);
    chk("done_seen", done, 1);
    if (done === 1'b1) begin
      chk("done_cyc", cyc, e0 + cur_dm + 3);
      chk("deg", deg, cur_deg);
      chk("busy_off", busy, 0);
      chk("q_empty", q.size(), 0);
      for (int k = 0; k <= cur_dm; k++) chk($sformatf("memS[%0d]", k), memS[k], expS[k]);
    end
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (write_enableS === 1'b1) begin
      if (q.size() == 0) chk("wr_extra", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("wr_addr", mem_address_iS, e.addr);
        chk("wr_data", mem_inputS, e.data);
        chk("wr_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    int e0;
    for (int i = 0; i < 2048; i++) begin
      memA[i] = 26'($urandom);
      memB[i] = 26'($urandom);
      memS[i] = 26'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_we", write_enableS, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_deg", deg, 0);
    chk("rst_addrA", mem_address_oA, 0);
    chk("rst_addrS", mem_address_iS, 0);
    chk("rst_dataS", mem_inputS, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sum: S={5,7,9}, deg 2, done after E5
    memA[0] = 26'd1; memA[1] = 26'd2; memA[2] = 26'd3;
    memB[0] = 26'd4; memB[1] = 26'd5; memB[2] = 26'd6;
    issue(2, 2, e0);
    wait_done(e0, 1'b0);
    chk("t1_deg", deg, 2);
    chk("t1_s1", memS[1], 7);

    // Unequal degrees; B beyond degB holds nonzero junk that must be masked
    for (int k = 0; k < 5; k++) memA[k] = 26'd1;
    memB[0] = 26'd2; memB[1] = 26'd2;
    for (int k = 2; k < 5; k++) memB[k] = 26'd9;
    issue(4, 1, e0);
    wait_done(e0, 1'b0);
    chk("t2_deg", deg, 4);
    chk("t2_s4", memS[4], 1);

    // Leading cancellation
    memA[0] = 26'd7; memA[1] = 26'd1; memA[2] = 26'h3FFFFFD;
    memB[0] = 26'd0; memB[1] = 26'd0; memB[2] = 26'd3;
    issue(2, 2, e0);
    wait_done(e0, 1'b0);
    chk("t3_deg", deg, 1);
    chk("t3_s2", memS[2], 0);

    // A = -B everywhere
    memA[0] = 26'd5;        memA[1] = 26'h3FFFFFF; memA[2] = 26'd100;
    memB[0] = 26'h3FFFFFB;  memB[1] = 26'd1;       memB[2] = 26'h3FFFF9C;
    issue(2, 2, e0);
    wait_done(e0, 1'b0);
    chk("t3b_deg", deg, 0);

    // Degree-0 pair near Q
    memA[0] = 26'd4590; memB[0] = 26'd5;
    issue(0, 0, e0);
    wait_done(e0, 1'b0);
`ifdef ADDPOLY_MODQ_EN
    chk("t4_s0", memS[0], 4);
`else
    chk("t4_s0", memS[0], 4595);
`endif

    // Start pulses at E1 and in the DONE cycle are ignored; next IDLE start accepted
    for (int k = 0; k < 4; k++) begin
      memA[k] = 26'(k + 10);
      memB[k] = 26'(k + 20);
    end
    issue(1, 3, e0);
    @(negedge clk);
    degA = 11'd0; degB = 11'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(e0, 1'b1);
    issue(2, 0, e0);
    wait_done(e0, 1'b0);

    // Asynchronous reset after E2 of a dmax=9 operation
    issue(9, 9, e0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_we", write_enableS, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    issue(9, 9, e0);
    wait_done(e0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
